// File: rtl/lap_memory_ctrl_if.sv
// Bundles the lap controller's stopwatch-side signals.
//   master: drives buttons, timer status and live time; observes the display and lap status.
//   slave : the lap controller; consumes the inputs and drives the display and lap status.
//   Time fields: hour/minute/second are 6 bits, m_sec (centiseconds) is 7 bits.
interface lap_memory_ctrl_if #(
   parameter int unsigned ADDR_W = 3
);
   logic              lap;
   logic              clear;
   logic              run_timer;
   logic              reset_timer;
   logic [5:0]        hour;
   logic [5:0]        minute;
   logic [5:0]        second;
   logic [6:0]        m_sec;
   logic [5:0]        disp_hour;
   logic [5:0]        disp_minute;
   logic [5:0]        disp_second;
   logic [6:0]        disp_m_sec;
   logic [ADDR_W:0]   lap_count;
   logic [ADDR_W:0]   lap_index;
   logic              reg_busy;

   modport master (
      output lap, clear, run_timer, reset_timer, hour, minute, second, m_sec,
      input  disp_hour, disp_minute, disp_second, disp_m_sec, lap_count, lap_index, reg_busy
   );

   modport slave (
      input  lap, clear, run_timer, reset_timer, hour, minute, second, m_sec,
      output disp_hour, disp_minute, disp_second, disp_m_sec, lap_count, lap_index, reg_busy
   );
endinterface

// File: rtl/lap_memory_ctrl.sv
// Stopwatch lap controller: captures the running time into a circular lap buffer, freezes a
// fresh capture on the display for HOLD_CYCLES, recalls stored laps newest-first, and sweeps the
// buffer to zero on clear.
//   clock_i : system clock
//   reset_i : asynchronous, active-high reset
//   bus_io  : slave side of lap_memory_ctrl_if (buttons, timer status, live time in;
//             display time, lap_count, lap_index, reg_busy out)
module lap_memory_ctrl #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned ADDR_W      = 3,
   parameter int unsigned HOLD_CYCLES = 150000000
) (
   input logic              clock_i,
   input logic              reset_i,
   lap_memory_ctrl_if.slave bus_io
);
   localparam int unsigned        CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [ADDR_W:0]    DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {StLive, StFrozen, StRecall, StClearing} state_e;

   state_e              state_q, state_d;
   logic                lap_q, clear_q, run_q;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [ADDR_W:0]     index_q, index_d;
   logic [CNT_W-1:0]    hold_q, hold_d;
   logic [24:0]         disp_q, disp_d;
   logic                busy_q, busy_d;
   logic [24:0]         mem_q [DEPTH];

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [24:0]         mem_wdata;
   logic [24:0]         live_time;
   logic                lap_p, clear_p, run_rise;

   assign live_time = {bus_io.hour, bus_io.minute, bus_io.second, bus_io.m_sec};
   assign lap_p     = bus_io.lap & ~lap_q;
   assign clear_p   = bus_io.clear & ~clear_q;
   assign run_rise  = bus_io.run_timer & ~run_q;

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      clr_ptr_d = clr_ptr_q;
      count_d   = count_q;
      index_d   = index_q;
      hold_d    = hold_q;
      disp_d    = disp_q;
      busy_d    = busy_q;
      mem_we    = 1'b0;
      mem_waddr = wr_ptr_q;
      mem_wdata = live_time;

      case (state_q)
         StClearing: begin
            // Buttons and timer requests are ignored until the sweep finishes.
            disp_d    = live_time;
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            if (clr_ptr_q == LAST_ADDR) begin
               state_d  = StLive;
               busy_d   = 1'b0;
               wr_ptr_d = '0;
               count_d  = '0;
               index_d  = '0;
            end else begin
               clr_ptr_d = clr_ptr_q + 1'b1;
            end
         end
         default: begin
            if (clear_p) begin
               state_d   = StClearing;
               busy_d    = 1'b1;
               clr_ptr_d = '0;
               index_d   = '0;
               disp_d    = live_time;
            end else if (bus_io.reset_timer) begin
               state_d = StLive;
               index_d = '0;
               disp_d  = live_time;
            end else if (lap_p && state_q != StRecall) begin
               if (bus_io.run_timer) begin
                  // Capture; when full the write pointer lands on the oldest entry.
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (count_q != DEPTH_CNT) count_d = count_q + 1'b1;
                  disp_d   = live_time;
                  hold_d   = HOLD_LOAD;
                  index_d  = (ADDR_W + 1)'(1);
                  state_d  = StFrozen;
               end else if (count_q != '0) begin
                  rd_ptr_d = wr_ptr_q - 1'b1;
                  disp_d   = mem_q[rd_ptr_d];
                  index_d  = (ADDR_W + 1)'(1);
                  state_d  = StRecall;
               end else begin
                  disp_d = live_time;
               end
            end else if (lap_p) begin
               // Step to the next older lap, wrapping back to the newest after the oldest.
               if (index_q >= count_q) begin
                  rd_ptr_d = wr_ptr_q - 1'b1;
                  index_d  = (ADDR_W + 1)'(1);
               end else begin
                  rd_ptr_d = rd_ptr_q - 1'b1;
                  index_d  = index_q + 1'b1;
               end
               disp_d = mem_q[rd_ptr_d];
            end else if (state_q == StFrozen) begin
               if (hold_q == '0) begin
                  state_d = StLive;
                  index_d = '0;
                  disp_d  = live_time;
               end else begin
                  hold_d = hold_q - 1'b1;
               end
            end else if (state_q == StRecall) begin
               if (run_rise) begin
                  state_d = StLive;
                  index_d = '0;
                  disp_d  = live_time;
               end
            end else begin
               disp_d = live_time;
            end
         end
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= StLive;
         lap_q     <= 1'b0;
         clear_q   <= 1'b0;
         run_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         clr_ptr_q <= '0;
         count_q   <= '0;
         index_q   <= '0;
         hold_q    <= '0;
         disp_q    <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lap_q     <= bus_io.lap;
         clear_q   <= bus_io.clear;
         run_q     <= bus_io.run_timer;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         clr_ptr_q <= clr_ptr_d;
         count_q   <= count_d;
         index_q   <= index_d;
         hold_q    <= hold_d;
         disp_q    <= disp_d;
         busy_q    <= busy_d;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign bus_io.disp_hour   = disp_q[24:19];
   assign bus_io.disp_minute = disp_q[18:13];
   assign bus_io.disp_second = disp_q[12:7];
   assign bus_io.disp_m_sec  = disp_q[6:0];
   assign bus_io.lap_count   = count_q;
   assign bus_io.lap_index   = index_q;
   assign bus_io.reg_busy    = busy_q;
endmodule

// File: doc/lap_memory_ctrl.md
Name: lap_memory_ctrl

Overview:
- Sequences lap capture, hold and recall for the stopwatch, sitting between the timer counters and the bin2bcd/bcd2seg display chain.
- Snapshots the running time into a small circular lap buffer on a debounced lap press.
- Selects whether the 7-segment chain shows live time, a frozen lap or a recalled lap.
- Clears the buffer on the clear button, asserting reg_busy while it sweeps.

Parameters:
- DEPTH, 8, number of lap entries; power of two, minimum 2.
- ADDR_W, 3, log2(DEPTH).
- HOLD_CYCLES, 150000000, clock cycles a freshly captured lap stays frozen on display (3 s at 50 MHz).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- lap  in  1  debounced lap button, active-high level.
- clear  in  1  debounced clear button, active-high level.
- run_timer  in  1  timer running, from key_logic_fsm.
- reset_timer  in  1  timer reset request, from key_logic_fsm.
- hour  in  6  live hours.
- minute  in  6  live minutes.
- second  in  6  live seconds.
- m_sec  in  7  live centiseconds.
- disp_hour  out  6  hours to display.
- disp_minute  out  6  minutes to display.
- disp_second  out  6  seconds to display.
- disp_m_sec  out  7  centiseconds to display.
- lap_count  out  ADDR_W+1  number of valid entries, 0..DEPTH.
- lap_index  out  ADDR_W+1  1-based age of the displayed entry (1 = newest); 0 in LIVE.
- reg_busy  out  1  high during CLEARING.

Behaviour:
- Reset (async): state=LIVE, wr_ptr=0, rd_ptr=0, lap_count=0, hold counter=0, all disp_* and lap_index = 0, reg_busy=0, all memory words=0.
- lap and clear are level inputs. Internal registered rising-edge detect gives lap_p and clear_p, each one cycle wide. Holding a button produces one event.
- Memory word is 25 bits: {hour, minute, second, m_sec}.
- Outputs are registered. In LIVE, disp_* equal the inputs delayed by 1 cycle.
- Priority per cycle: clear_p > reset_timer > lap_p > hold expiry / run_timer edge.
- State LIVE:
  - lap_p && run_timer: write the current input time to mem[wr_ptr]; wr_ptr++ with wrap; lap_count saturates at DEPTH, and the oldest entry is overwritten when full. Latch the captured value onto disp_*, load the hold counter with HOLD_CYCLES-1, set lap_index=1, go to FROZEN.
  - lap_p && !run_timer && lap_count>0: rd_ptr = wr_ptr-1, show mem[rd_ptr], lap_index=1, go to RECALL.
  - lap_p && !run_timer && lap_count=0: ignored.
- State FROZEN:
  - disp_* hold the captured value; the hold counter decrements every cycle.
  - At 0: go to LIVE.
  - lap_p: capture again exactly as in LIVE and reload the counter.
  - If run_timer falls, keep counting down.
- State RECALL:
  - Each lap_p: rd_ptr-- with wrap; lap_index++. Once lap_index has reached lap_count, the next press returns to the newest entry (lap_index=1).
  - Rising edge of run_timer: go to LIVE.
- reset_timer=1 in FROZEN or RECALL: go to LIVE next cycle. Lap entries are preserved.
- clear_p in any state except CLEARING: go to CLEARING and set reg_busy=1.
  - Write zero to mem[0..DEPTH-1], one address per cycle, for exactly DEPTH cycles.
  - Then wr_ptr=0, lap_count=0, lap_index=0, reg_busy=0, state=LIVE.
  - lap_p and clear_p are ignored during CLEARING; disp_* show live time.
- Simultaneous lap_p and clear_p: clear wins and the lap is discarded.
- Memory is single-write-port, read-after-write. A capture and a recall can never happen in the same cycle.

Test Plan:
- Capture with hold: HOLD_CYCLES=16, run_timer=1, time 00:01:02.34, lap pulse -> 1 cycle later disp shows 00:01:02.34, lap_count=1, lap_index=1; 16 cycles later disp tracks live time and lap_index=0.
- Overflow: DEPTH=4, six captures of times T1..T6 while running -> lap_count=4; recall with run_timer=0 shows T6, T5, T4, T3, then T6 again, with lap_index 1, 2, 3, 4, 1.
- Recall exit: in RECALL, raise run_timer -> LIVE next cycle, lap_index=0. In a separate run, reset_timer=1 during FROZEN -> LIVE next cycle with lap_count unchanged.
- Clear sweep: 3 laps stored, clear pulse -> reg_busy high for exactly DEPTH cycles; a lap pulse during the sweep has no effect; afterwards lap_count=0, and a lap press with run_timer=0 is ignored.
- Simultaneous lap and clear on the same cycle -> no capture, CLEARING entered. Holding lap high for 100 cycles -> exactly one capture.
- Async reset asserted mid-FROZEN and mid-CLEARING -> all outputs 0 immediately, without waiting for a clock edge; LIVE after reset release.
